// File: rtl/outputc_if.sv
// Output-port bundle: input-side request/flit/grant lines plus the downstream link,
// ready and status lines. The flit travels as a flat vector and is typed inside the block.
interface outputc_if #(
  parameter int PORT_N = 5,
  parameter int VCH_N  = 2,
  parameter int FLIT_W = 34
);
  logic [PORT_N-1:0]             req_i;
  logic [PORT_N-1:0][FLIT_W-1:0] flit_i;
  logic [PORT_N-1:0]             grt_o;
  logic [VCH_N-1:0]              dn_rdy_i;
  logic [FLIT_W-1:0]             outputc_o;
  logic [VCH_N-1:0]              lck_o;
  logic                          err_o;

  modport master (
    output req_i, flit_i, dn_rdy_i,
    input  grt_o, outputc_o, lck_o, err_o
  );

  modport slave (
    input  req_i, flit_i, dn_rdy_i,
    output grt_o, outputc_o, lck_o, err_o
  );
endinterface

// File: rtl/outputc.sv
// Router output controller: per-VC packet locking, round-robin arbitration over the
// input channels and a registered link stage, with a sticky protocol-error flag.
package outputc_pkg;
  localparam int PORT_N   = 5;
  localparam int PORT_W   = 3;
  localparam int VCH_N    = 2;
  localparam int VCH_W    = 1;
  localparam int DATA_W   = 32;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 29;

  typedef enum logic [2:0] {
    TYPE_NONE     = 3'd0,
    TYPE_HEAD     = 3'd1,
    TYPE_BODY     = 3'd2,
    TYPE_TAIL     = 3'd3,
    TYPE_HEADTAIL = 3'd4
  } flit_type_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [VCH_W-1:0]  vch;
  } router_i_t;

  localparam int FLIT_W = $bits(router_i_t);
endpackage

module outputc
  import outputc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  outputc_if.slave   io
);

  typedef enum logic {
    VC_FREE   = 1'b0,
    VC_LOCKED = 1'b1
  } vc_state_e;

  vc_state_e         state_q [VCH_N];
  vc_state_e         state_d [VCH_N];
  logic [PORT_W-1:0] owner_q [VCH_N];
  logic [PORT_W-1:0] owner_d [VCH_N];
  logic [PORT_W-1:0] rr_q, rr_d;
  router_i_t         outc_q, outc_d;
  logic              err_q, err_d;

  router_i_t         flit_s [PORT_N];
  flit_type_e        typ_s  [PORT_N];
  logic [PORT_N-1:0] elig_s;
  logic [PORT_N-1:0] bad_s;
  logic [PORT_N-1:0] grt_s;
  logic [PORT_W-1:0] gidx_s;
  logic              found_s;
  logic [VCH_N-1:0]  lck_s;

  // The identifiers only tag error reports at system level; negative values are meaningless.
  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
  end

  // Decode each candidate flit and classify it as grantable, waiting or illegal.
  always_comb begin
    elig_s = '0;
    bad_s  = '0;
    for (int p = 0; p < PORT_N; p++) begin
      logic active;
      logic legal;
      logic illegal;
      flit_s[p] = router_i_t'(io.flit_i[p]);
      typ_s[p]  = flit_type_e'(flit_s[p].data[TYPE_MSB:TYPE_LSB]);
      active    = io.req_i[p] & flit_s[p].valid;
      case (typ_s[p])
        TYPE_HEAD, TYPE_HEADTAIL: begin
          legal   = (state_q[flit_s[p].vch] == VC_FREE);
          illegal = 1'b0;
        end
        TYPE_BODY, TYPE_TAIL: begin
          legal   = (state_q[flit_s[p].vch] == VC_LOCKED) &&
                    (owner_q[flit_s[p].vch] == PORT_W'(p));
          illegal = !legal;
        end
        default: begin
          legal   = 1'b0;
          illegal = 1'b1;
        end
      endcase
      elig_s[p] = active & io.dn_rdy_i[flit_s[p].vch] & legal;
      bad_s[p]  = active & illegal;
    end
  end

  // Round-robin pick: search begins one past the last granted input.
  always_comb begin
    logic [PORT_W:0] idx;
    grt_s   = '0;
    found_s = 1'b0;
    gidx_s  = rr_q;
    for (int k = 1; k <= PORT_N; k++) begin
      idx = {1'b0, rr_q} + (PORT_W+1)'(k);
      if (idx >= (PORT_W+1)'(PORT_N)) begin
        idx = idx - (PORT_W+1)'(PORT_N);
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[idx[PORT_W-1:0]]) begin
        found_s                  = 1'b1;
        gidx_s                   = idx[PORT_W-1:0];
        grt_s[idx[PORT_W-1:0]]   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // VC lock FSMs, pointer, link register and error flag next-state.
  always_comb begin
    for (int v = 0; v < VCH_N; v++) begin
      state_d[v] = state_q[v];
      owner_d[v] = owner_q[v];
    end
    rr_d   = rr_q;
    outc_d = '0;
    err_d  = err_q | (|bad_s);
    if (found_s) begin
      rr_d         = gidx_s;
      outc_d       = flit_s[gidx_s];
      outc_d.valid = 1'b1;
      case (typ_s[gidx_s])
        TYPE_HEAD: begin
          state_d[flit_s[gidx_s].vch] = VC_LOCKED;
          owner_d[flit_s[gidx_s].vch] = gidx_s;
        end
        TYPE_TAIL: begin
          state_d[flit_s[gidx_s].vch] = VC_FREE;
          owner_d[flit_s[gidx_s].vch] = '0;
        end
        default: ;
      endcase
    end else begin
      outc_d = '0;
    end
  end

  // State registers; reset leaves input 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VCH_N; v++) begin
        state_q[v] <= VC_FREE;
        owner_q[v] <= '0;
      end
      rr_q   <= PORT_W'(PORT_N - 1);
      outc_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int v = 0; v < VCH_N; v++) begin
        state_q[v] <= state_d[v];
        owner_q[v] <= owner_d[v];
      end
      rr_q   <= rr_d;
      outc_q <= outc_d;
      err_q  <= err_d;
    end
  end

  // Lock status straight from the VC state flops.
  always_comb begin
    lck_s = '0;
    for (int v = 0; v < VCH_N; v++) begin
      lck_s[v] = (state_q[v] == VC_LOCKED);
    end
  end

  assign io.grt_o     = grt_s;
  assign io.outputc_o = outc_q;
  assign io.lck_o     = lck_s;
  assign io.err_o     = err_q;

endmodule

// File: tb/tb_outputc.sv
// Directed bench for outputc: grants checked combinationally, link flits via a scoreboard queue.
module tb_outputc;
  import outputc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  router_i_t fl [PORT_N];
  router_i_t exp_q [$];

  outputc_if #(.PORT_N(PORT_N), .VCH_N(VCH_N), .FLIT_W(FLIT_W)) io ();

  outputc #(.ROUTERID(0), .PCHID(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drv(input int p, input flit_type_e t, input int v, input logic [28:0] pay);
    fl[p].data  = {t, pay};
    fl[p].valid = 1'b1;
    fl[p].vch   = VCH_W'(v);
    io.req_i[p]  = 1'b1;
    io.flit_i[p] = fl[p];
  endtask

  task automatic idle(input int p);
    fl[p]        = '0;
    io.req_i[p]  = 1'b0;
    io.flit_i[p] = '0;
  endtask

  task automatic idle_all();
    for (int p = 0; p < PORT_N; p++) idle(p);
  endtask

  // One cycle: check grant at the falling edge, then the link output just after the rising edge.
  task automatic step(input logic [PORT_N-1:0] exp_grt, input string tag);
    router_i_t e;
    @(negedge clk);
    chk({tag, "_grt"}, 64'(io.grt_o), 64'(exp_grt));
    for (int p = 0; p < PORT_N; p++) begin
      if (exp_grt[p]) exp_q.push_back(fl[p]);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, 64'(io.outputc_o), 64'(e));
    end else begin
      chk({tag, "_idle"}, 64'(io.outputc_o), 64'd0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    io.req_i    = '0;
    io.flit_i   = '0;
    io.dn_rdy_i = 2'b11;
    for (int p = 0; p < PORT_N; p++) fl[p] = '0;

    // Reset state held until release
    #3;
    chk("rst_out", 64'(io.outputc_o), 64'd0);
    chk("rst_lck", 64'(io.lck_o), 64'd0);
    chk("rst_err", 64'(io.err_o), 64'd0);
    chk("rst_grt", 64'(io.grt_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out", 64'(io.outputc_o), 64'd0);
    rst_n = 1'b1;

    // Single HEADTAIL from input 2 to vch 1
    drv(2, TYPE_HEADTAIL, 1, 29'h0000_0AA);
    step(5'b00100, "ht");
    chk("ht_lck", 64'(io.lck_o), 64'd0);
    idle_all();
    step(5'b00000, "ht_after");

    // Packet from input 1 on vch 0 blocks a head from input 3
    drv(1, TYPE_HEAD, 0, 29'h0000_111);
    step(5'b00010, "p1_head");
    chk("p1_lck_h", 64'(io.lck_o), 64'd1);
    drv(1, TYPE_BODY, 0, 29'h0000_112);
    drv(3, TYPE_HEAD, 0, 29'h0000_333);
    step(5'b00010, "p1_body");
    chk("p1_lck_b", 64'(io.lck_o), 64'd1);
    drv(1, TYPE_TAIL, 0, 29'h0000_113);
    step(5'b00010, "p1_tail");
    chk("p1_lck_t", 64'(io.lck_o), 64'd0);
    idle(1);
    step(5'b01000, "p3_head");
    chk("p3_lck", 64'(io.lck_o), 64'd1);
    drv(3, TYPE_TAIL, 0, 29'h0000_334);
    step(5'b01000, "p3_tail");
    chk("p3_lck_t", 64'(io.lck_o), 64'd0);
    chk("p3_err", 64'(io.err_o), 64'd0);
    idle_all();

    // Reset restores input-0 priority; continuous HEADTAILs rotate 0,1,4
    rst_n = 1'b0;
    #1;
    chk("rr_rst_out", 64'(io.outputc_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(0, TYPE_HEADTAIL, 0, 29'h0000_A00);
    drv(1, TYPE_HEADTAIL, 0, 29'h0000_A01);
    drv(4, TYPE_HEADTAIL, 0, 29'h0000_A04);
    step(5'b00001, "rr0");
    step(5'b00010, "rr1");
    step(5'b10000, "rr4");
    step(5'b00001, "rr0b");
    step(5'b00010, "rr1b");
    step(5'b10000, "rr4b");
    idle_all();

    // Downstream stall on vch 1 mid-packet while vch 0 keeps flowing
    drv(2, TYPE_HEAD, 1, 29'h0000_B20);
    step(5'b00100, "st_head");
    drv(2, TYPE_BODY, 1, 29'h0000_B21);
    drv(0, TYPE_HEADTAIL, 0, 29'h0000_C00);
    io.dn_rdy_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step(5'b00001, "st_stall");
      chk("st_lck", 64'(io.lck_o), 64'd2);
    end
    io.dn_rdy_i = 2'b11;
    step(5'b00100, "st_body1");
    step(5'b00001, "st_il");
    idle(0);
    drv(2, TYPE_TAIL, 1, 29'h0000_B22);
    step(5'b00100, "st_tail");
    chk("st_lck_t", 64'(io.lck_o), 64'd0);
    chk("st_err", 64'(io.err_o), 64'd0);
    idle_all();

    // BODY to a free VC: refused, sticky error; other input still served
    drv(2, TYPE_BODY, 0, 29'h0000_D20);
    drv(1, TYPE_HEADTAIL, 1, 29'h0000_D11);
    step(5'b00010, "er_body");
    chk("er_set", 64'(io.err_o), 64'd1);
    idle_all();
    step(5'b00000, "er_idle");
    chk("er_hold", 64'(io.err_o), 64'd1);

    // Reset between HEAD and TAIL drops the lock; following BODY is an error
    rst_n = 1'b0;
    #1;
    chk("mr_err_clr", 64'(io.err_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(0, TYPE_HEAD, 1, 29'h0000_E00);
    step(5'b00001, "mr_head");
    chk("mr_lck", 64'(io.lck_o), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_lck_async", 64'(io.lck_o), 64'd0);
    chk("mr_out_async", 64'(io.outputc_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(0, TYPE_BODY, 1, 29'h0000_E01);
    step(5'b00000, "mr_body");
    chk("mr_err", 64'(io.err_o), 64'd1);
    chk("mr_lck_free", 64'(io.lck_o), 64'd0);
    idle_all();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/outputc.md
OUTPUTC -- requirements
Module: outputc

Interface
REQ-001 Parameter ROUTERID, default 0, router identifier; used only for error reporting.
REQ-002 Parameter PCHID, default 0, index of the physical output channel this instance drives.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  PORT_N  per-input-channel request for this output port.
REQ-006 flit_i  input  PORT_N x router_i_t  candidate flit per input channel: data, valid, target vch.
REQ-007 grt_o  output  PORT_N  one-hot grant to the input channel whose flit is accepted this cycle.
REQ-008 dn_rdy_i  input  VCH_N  per-VC ready from the downstream input-channel FIFO.
REQ-009 outputc_o  output  router_i_t  registered flit onto the link: data, valid, vch.
REQ-010 lck_o  output  VCH_N  per-VC packet-lock status, 1 while a packet owns that VC.
REQ-011 err_o  output  1  sticky protocol-violation flag.

Function
REQ-012 Flit type is taken from flit_i[p].data[TYPE_MSB:TYPE_LSB]; the target VC is flit_i[p].vch.
REQ-013 Each VC has a two-state FSM: FREE and LOCKED, with a PORT_W-bit owner register.
REQ-014 Input p is eligible when req_i[p], flit_i[p].valid and dn_rdy_i[v] are all 1, and one of the following holds:
- VC v is FREE and the type is TYPE_HEAD or TYPE_HEADTAIL; or
- VC v is LOCKED with owner == p and the type is TYPE_BODY or TYPE_TAIL.
REQ-015 At most one grant per cycle; grt_o is combinational, one-hot or zero.
REQ-016 Selection is round-robin: the search starts at (last granted index + 1) mod PORT_N; the pointer updates only on a grant.
REQ-017 Granted flit appears on outputc_o exactly one cycle later with valid=1; otherwise outputc_o.valid=0 and data=0.
REQ-018 Transition FREE->LOCKED (owner=p) on a granted TYPE_HEAD.
REQ-019 Transition LOCKED->FREE on a granted TYPE_TAIL from the owner.
REQ-020 A granted TYPE_HEADTAIL leaves the VC FREE.
REQ-021 lck_o[v]=1 while VC v is LOCKED, registered, so it changes the cycle after the lock/unlock grant.
REQ-022 A VC unlocked in cycle N is available to a new head in cycle N+1, not in cycle N.
REQ-023 dn_rdy_i[v]=0 blocks all grants to VC v; an owner's body flits stall without losing the lock.
REQ-024 err_o sets and holds on a request with valid=1 that is never legal in the current VC state:
- body/tail to a FREE VC;
- body/tail from a non-owner;
- TYPE_NONE with valid=1.
REQ-025 An offending request is never granted; normal operation continues on other inputs.
REQ-026 A head request to a VC LOCKED by another input is not an error; it waits.
REQ-027 Requests to different VCs compete in the same round-robin; VCs interleave flit-by-flit on the link.

Reset
REQ-028 On rst_n=0, asynchronously:
- all VCs go FREE and owners go 0;
- the round-robin pointer is set so input 0 has first priority;
- outputc_o, lck_o and err_o go to 0.
REQ-029 Reset mid-packet drops the lock; the first flit accepted after reset must be a head.
REQ-030 Outputs are stable at reset values until the first rising edge with rst_n=1.

Verification
REQ-031 Single HEADTAIL from input 2 to vch 1, dn_rdy=11:
- grt_o=00100 in cycle N;
- outputc_o valid with vch 1 in N+1;
- lck_o stays 00.
REQ-032 Input 1 sends HEAD,BODY,TAIL on vch 0 while input 3 sends HEAD on vch 0:
- input 3 is not granted until the cycle after input 1's TAIL is granted;
- lck_o[0]=1 from after HEAD to after TAIL.
REQ-033 Inputs 0,1,4 hold HEADTAIL requests continuously on vch 0, dn_rdy=11: grant order is 0,1,4,0,1,4.
REQ-034 dn_rdy_i[1]=0 for 5 cycles mid-packet on vch 1:
- no grants to vch 1;
- lck_o[1] remains 1;
- the packet resumes intact when ready returns.
REQ-035 BODY from input 2 to a FREE VC: no grant, err_o=1 next cycle and held.
REQ-036 rst_n asserted between HEAD and TAIL: lck_o=00 immediately; a subsequent BODY raises err_o.
